// File: rtl/alu_exec_pkg.sv
// alu_exec_pkg: shared definitions for the ALU execution unit.
//   alu_control_t     - 3-bit operation code from the control-path ALU decoder
//   state_t           - execution FSM states
//   ALU_WIDTH_DEFAULT - default operand/result width
package alu_exec_pkg;

  localparam int unsigned ALU_WIDTH_DEFAULT = 32;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLL = 3'b100,
    ALU_SLT = 3'b101,
    ALU_SRL = 3'b110,
    ALU_SRA = 3'b111
  } alu_control_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_exec_comb.sv
// alu_exec_comb: purely combinational single-cycle ALU operations.
//   i_alu_control - operation code
//   i_src_a/b     - operands
//   o_result      - ADD/SUB/AND/OR/SLT result; 0 for codes not handled here
//   o_illegal     - code is not a single-cycle op (shift codes are flagged
//                   here; the top overrides that when shifts are compiled in)
module alu_exec_comb
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic [2:0]       i_alu_control,
  input  logic [WIDTH-1:0] i_src_a,
  input  logic [WIDTH-1:0] i_src_b,
  output logic [WIDTH-1:0] o_result,
  output logic             o_illegal
);

  logic w_lt;
  assign w_lt = ($signed(i_src_a) < $signed(i_src_b));

  always_comb begin
    o_result  = '0;
    o_illegal = 1'b0;
    case (alu_control_t'(i_alu_control))
      ALU_ADD: o_result = i_src_a + i_src_b;
      ALU_SUB: o_result = i_src_a - i_src_b;
      ALU_AND: o_result = i_src_a & i_src_b;
      ALU_OR:  o_result = i_src_a | i_src_b;
      ALU_SLT: o_result = {{(WIDTH-1){1'b0}}, w_lt};
      ALU_SLL, ALU_SRL, ALU_SRA: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: handshaked ALU execution unit with registered result.
// Optional feature macro: ALU_EXEC_SHIFT_EN (iterative SLL/SRL/SRA, 1 bit/cycle).
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid/in_ready    - request handshake; alu_control/src_a/src_b sampled on accept
//   out_valid/out_ready  - result handshake
//   result, zero, illegal - registered result, result==0, unsupported-code flag
module alu_exec_unit
  import alu_exec_pkg::*;
#(
  parameter int unsigned WIDTH = ALU_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       alu_control,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  logic [WIDTH-1:0] w_comb_res;
  logic             w_comb_ill;
  logic [WIDTH-1:0] w_load_res;
  logic             w_load_ill;
  logic             w_idle;
  logic             w_accept;
  logic             w_consume;

  logic             r_out_valid;
  logic [WIDTH-1:0] r_result;
  logic             r_zero;
  logic             r_illegal;

  alu_exec_comb #(.WIDTH(WIDTH)) u_comb (
    .i_alu_control (alu_control),
    .i_src_a       (src_a),
    .i_src_b       (src_b),
    .o_result      (w_comb_res),
    .o_illegal     (w_comb_ill)
  );

`ifdef ALU_EXEC_SHIFT_EN
  localparam int unsigned SHW = $clog2(WIDTH);

  state_t           r_state;
  logic [WIDTH-1:0] r_work;
  logic [SHW-1:0]   r_cnt;
  alu_control_t     r_op;
  alu_control_t     w_op;
  logic             w_is_shift;
  logic [SHW-1:0]   w_shamt;

  assign w_op       = alu_control_t'(alu_control);
  assign w_is_shift = (w_op == ALU_SLL) || (w_op == ALU_SRL) || (w_op == ALU_SRA);
  assign w_shamt    = src_b[SHW-1:0];
  assign w_idle     = (r_state == IDLE);

  // A shift reaching the single-cycle load path always has shamt==0: pass src_a.
  always_comb begin
    w_load_res = w_comb_res;
    w_load_ill = w_comb_ill;
    if (w_is_shift) begin
      w_load_res = src_a;
      w_load_ill = 1'b0;
    end
  end
`else
  assign w_idle     = 1'b1;
  assign w_load_res = w_comb_res;
  assign w_load_ill = w_comb_ill;
`endif

  assign in_ready  = w_idle && (!r_out_valid || out_ready);
  assign w_accept  = in_valid && in_ready;
  assign w_consume = r_out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      r_state     <= IDLE;
      r_work      <= '0;
      r_cnt       <= '0;
      r_op        <= ALU_ADD;
`endif
    end else begin
      // Consumption clears out_valid; a load later in this block re-sets it.
      if (w_consume) r_out_valid <= 1'b0;
`ifdef ALU_EXEC_SHIFT_EN
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            if (w_is_shift && (w_shamt != '0)) begin
              r_state <= SHIFT;
              r_work  <= src_a;
              r_cnt   <= w_shamt;
              r_op    <= w_op;
            end else begin
              r_result    <= w_load_res;
              r_zero      <= (w_load_res == '0);
              r_illegal   <= w_load_ill;
              r_out_valid <= 1'b1;
            end
          end
        end
        SHIFT: begin
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
            case (r_op)
              ALU_SLL: r_work <= r_work << 1;
              ALU_SRL: r_work <= r_work >> 1;
              default: r_work <= {r_work[WIDTH-1], r_work[WIDTH-1:1]};
            endcase
          end else if (!r_out_valid) begin
            r_result    <= r_work;
            r_zero      <= (r_work == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
`else
      if (w_accept) begin
        r_result    <= w_load_res;
        r_zero      <= (w_load_res == '0);
        r_illegal   <= w_load_ill;
        r_out_valid <= 1'b1;
      end
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   alu_control;
  logic [W-1:0] src_a;
  logic [W-1:0] src_b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         illegal;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_control (alu_control),
    .src_a       (src_a),
    .src_b       (src_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .result      (result),
    .zero        (zero),
    .illegal     (illegal)
  );

  // Reference: what each code means, from the operation table.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] r,
                                output logic ill, output int lat);
    int sh;
    sh  = int'(b % W);
    r   = '0;
    ill = 1'b0;
    lat = 1;
    case (op)
      3'd0: r = a + b;
      3'd1: r = a - b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd5: r = ($signed(a) < $signed(b)) ? 1 : 0;
      default: begin
`ifdef ALU_EXEC_SHIFT_EN
        if (op == 3'd4)      r = a << sh;
        else if (op == 3'd6) r = a >> sh;
        else                 r = W'($signed(a) >>> sh);
        lat = (sh == 0) ? 1 : sh + 1;
`else
        ill = 1'b1;
`endif
      end
    endcase
  endfunction

  // Issues one request and waits for its result; phase: #1 after posedge.
  // lat = edges from accept to out_valid visible; 999 = never arrived.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output logic [W-1:0] r, output logic z, output logic ill,
                        output int lat, output int ready_seen);
    int guard;
    out_ready = 1'b1;
    in_valid = 1'b1; alu_control = op; src_a = a; src_b = b;
    guard = 0;
    while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1; ready_seen = 0;
    while (!out_valid && lat < 200) begin
      if (in_ready) ready_seen++;
      @(posedge clk); #1; lat++;
    end
    if (!out_valid) lat = 999;
    r = result; z = zero; ill = illegal;
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({out_valid, result, zero, illegal, in_ready} !== {1'b0, 32'h0, 1'b0, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset: ov=%b res=%h z=%b ill=%b rdy=%b, want 0 0 0 0 1",
               out_valid, result, zero, illegal, in_ready);
    end
  endtask

  task automatic test_add();
    logic [W-1:0] r; logic z, ill; int lat, rs;
    run_op(3'd0, 32'd5, 32'd7, r, z, ill, lat, rs);
    n_cmp++;
    if ({r, z, ill} !== {32'd12, 1'b0, 1'b0} || lat != 1) begin
      n_fail++;
      $display("FAIL add: res=%0d z=%b ill=%b lat=%0d, want 12 0 0 1", r, z, ill, lat);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    in_valid = 1'b1; alu_control = 3'd1; src_a = 32'd9; src_b = 32'd9;
    @(posedge clk); #1;
    n_cmp++;
    if ({out_valid, result, zero, in_ready} !== {1'b1, 32'd0, 1'b1, 1'b1}) begin
      n_fail++;
      $display("FAIL b2b_sub: ov=%b res=%h z=%b rdy=%b, want 1 0 1 1", out_valid, result, zero, in_ready);
    end
    alu_control = 3'd5; src_a = 32'hFFFF_FFFF; src_b = 32'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, result, zero, illegal} !== {1'b1, 32'd1, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL b2b_slt: ov=%b res=%h z=%b ill=%b, want 1 1 0 0", out_valid, result, zero, illegal);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_drain: ov=%b, want 0", out_valid);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'd3; src_a = 32'hF0; src_b = 32'h0F;
    @(posedge clk); #1;
    alu_control = 3'd0; src_a = 32'd1; src_b = 32'd2;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid, result, in_ready} !== {1'b1, 32'hFF, 1'b0}) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%b res=%h rdy=%b, want 1 ff 0", i, out_valid, result, in_ready);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_ready: rdy=%b, want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_cmp++;
    if ({out_valid, result} !== {1'b1, 32'd3}) begin
      n_fail++;
      $display("FAIL bp_next: ov=%b res=%h, want 1 3", out_valid, result);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_shift_codes();
    logic [W-1:0] r; logic z, ill; int lat, rs;
`ifdef ALU_EXEC_SHIFT_EN
    run_op(3'd7, 32'h8000_0000, 32'd4, r, z, ill, lat, rs);
    n_cmp++;
    if ({r, ill} !== {32'hF800_0000, 1'b0} || lat != 5) begin
      n_fail++;
      $display("FAIL sra4: res=%h ill=%b lat=%0d, want f8000000 0 5", r, ill, lat);
    end
    run_op(3'd4, 32'hDEAD_BEEF, 32'h20, r, z, ill, lat, rs);
    n_cmp++;
    if ({r, ill} !== {32'hDEAD_BEEF, 1'b0} || lat != 1) begin
      n_fail++;
      $display("FAIL sll0: res=%h ill=%b lat=%0d, want deadbeef 0 1", r, ill, lat);
    end
    run_op(3'd4, 32'd1, 32'd31, r, z, ill, lat, rs);
    n_cmp++;
    if (r !== 32'h8000_0000 || lat != 32 || rs != 0) begin
      n_fail++;
      $display("FAIL sll31: res=%h lat=%0d ready_cycles=%0d, want 80000000 32 0", r, lat, rs);
    end
`else
    for (int c = 0; c < 3; c++) begin
      logic [2:0] code;
      code = (c == 0) ? 3'd4 : (c == 1) ? 3'd6 : 3'd7;
      run_op(code, 32'h1234_5678, 32'd3, r, z, ill, lat, rs);
      n_cmp++;
      if ({r, z, ill} !== {32'd0, 1'b1, 1'b1} || lat != 1) begin
        n_fail++;
        $display("FAIL illegal_%0d: res=%h z=%b ill=%b lat=%0d, want 0 1 1 1", code, r, z, ill, lat);
      end
    end
`endif
  endtask

  task automatic test_random();
    logic [W-1:0] a, b, r, er; logic z, ill, eill; int lat, elat, rs;
    logic [2:0] op;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 5) == 0) a = '0;
      model(op, a, b, er, eill, elat);
      run_op(op, a, b, r, z, ill, lat, rs);
      n_cmp++;
      if ({r, z, ill} !== {er, (er == '0), eill} || lat != elat) begin
        n_fail++;
        $display("FAIL rand[%0d] op=%0d a=%h b=%h: res=%h z=%b ill=%b lat=%0d, want %h %b %b %0d",
                 i, op, a, b, r, z, ill, lat, er, (er == '0), eill, elat);
      end
    end
  endtask

  task automatic test_reset_abort();
    out_ready = 1'b1;
`ifdef ALU_EXEC_SHIFT_EN
    in_valid = 1'b1; alu_control = 3'd4; src_a = 32'h5; src_b = 32'd10;
`else
    out_ready = 1'b0;
    in_valid = 1'b1; alu_control = 3'd3; src_a = 32'h55; src_b = 32'h0;
`endif
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid, result, zero, illegal} !== {1'b0, 32'h0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL rst_async: ov=%b res=%h z=%b ill=%b, want 0 0 0 0", out_valid, result, zero, illegal);
    end
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({out_valid, in_ready} !== {1'b0, 1'b1}) begin
        n_fail++;
        $display("FAIL rst_after[%0d]: ov=%b rdy=%b, want 0 1", i, out_valid, in_ready);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_control = '0; src_a = '0; src_b = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_shift_codes();
    test_random();
    test_reset_abort();
    test_add();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
